// File: rtl/data_mem_bank.sv
// data_mem_bank
//   Single-port word-addressed data memory with a request/grant front end and
//   a fixed-latency response. At most one request is in flight: the grant is
//   offered only in IDLE or in the RESP cycle of the previous request. All
//   request fields are sampled at the grant edge. Writes commit at that edge,
//   and read data is also captured there, so a read granted in the RESP cycle
//   of a write to the same word sees the new value.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   data_req_in    request valid
//   data_add_in    byte address, word index = data_add_in[31:2]
//   data_we_in     1 = write, 0 = read
//   data_be_in     byte-lane mask (bit i selects data byte i)
//   data_wdata_in  write data
//   rd_in_data     request tag
//   data_gnt_o     request accepted this cycle (combinational)
//   data_rvalid    one-cycle response pulse
//   data_rdata_o   read data (0 for writes and errors)
//   rd_out_data    tag of the response
//   data_err_o     response carries an error (illegal mask or index >= DEPTH)
module data_mem_bank #(
  parameter int DEPTH      = 8000,
  parameter int LATENCY    = 1,
  parameter int TAG_W      = 5,
  parameter int BIG_ENDIAN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_req_in,
  input  logic [31:0]      data_add_in,
  input  logic             data_we_in,
  input  logic [3:0]       data_be_in,
  input  logic [31:0]      data_wdata_in,
  input  logic [TAG_W-1:0] rd_in_data,
  output logic             data_gnt_o,
  output logic             data_rvalid,
  output logic [31:0]      data_rdata_o,
  output logic [TAG_W-1:0] rd_out_data,
  output logic             data_err_o
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  // WAIT is entered with LATENCY-2 so that RESP follows LATENCY-1 edges later.
  localparam logic [1:0]  CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      pend_rdata_q, pend_rdata_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic             pend_err_q, pend_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  logic [31:0]      mem_q [DEPTH];

  logic [29:0]      word_idx;
  logic [AW-1:0]    mem_idx;
  logic             addr_err, mask_err, req_err;
  logic             gnt;
  logic             wr_en;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic [31:0]      new_rdata;
  logic             unused_addr_lsbs;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign word_idx         = data_add_in[31:2];
  assign mem_idx          = word_idx[AW-1:0];
  assign unused_addr_lsbs = ^data_add_in[1:0];
  assign addr_err         = {2'b00, word_idx} >= DEPTH_W;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a value on every
    // path (here via the default arm); a missing branch would infer a latch.
    unique case (data_be_in)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_err = 1'b0;
      default:                   mask_err = 1'b1;
    endcase
  end

  assign req_err = addr_err | mask_err;

  // Big-endian storage reverses the byte order; the same reversal undoes it
  // on the read side.
  always_comb begin
    wr_en   = gnt & data_we_in & ~req_err;
    wr_data = (BIG_ENDIAN != 0) ? byte_swap(data_wdata_in) : data_wdata_in;
    wr_mask = (BIG_ENDIAN != 0) ? {data_be_in[0], data_be_in[1], data_be_in[2], data_be_in[3]}
                                : data_be_in;
    rd_word = (BIG_ENDIAN != 0) ? byte_swap(mem_q[mem_idx]) : mem_q[mem_idx];
    new_rdata = (req_err | data_we_in) ? 32'd0 : rd_word;
  end

  // NOTE: the storage array has no reset; its contents survive rst, and only
  // the control and response registers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_mask[0]) mem_q[mem_idx][7:0]   <= wr_data[7:0];
      if (wr_mask[1]) mem_q[mem_idx][15:8]  <= wr_data[15:8];
      if (wr_mask[2]) mem_q[mem_idx][23:16] <= wr_data[23:16];
      if (wr_mask[3]) mem_q[mem_idx][31:24] <= wr_data[31:24];
    end
  end

  // State register and response registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      pend_rdata_q <= 32'd0;
      pend_tag_q   <= '0;
      pend_err_q   <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rdata_q <= pend_rdata_d;
      pend_tag_q   <= pend_tag_d;
      pend_err_q   <= pend_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next-state logic. The pending registers hold a granted request while it
  // waits; the response registers change only on the edge that enters RESP,
  // so the outputs stay put between responses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rdata_d = pend_rdata_q;
    pend_tag_d   = pend_tag_q;
    pend_err_d   = pend_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (gnt) begin
          pend_rdata_d = new_rdata;
          pend_tag_d   = rd_in_data;
          pend_err_d   = req_err;
          if (LATENCY == 1) begin
            state_d     = S_RESP;
            rsp_rdata_d = new_rdata;
            rsp_tag_d   = rd_in_data;
            rsp_err_d   = req_err;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = S_RESP;
          rsp_rdata_d = pend_rdata_q;
          rsp_tag_d   = pend_tag_q;
          rsp_err_d   = pend_err_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. The grant is gated by rst so nothing is accepted while the
  // block is held in reset.
  always_comb begin
    gnt         = data_req_in & ~rst & ((state_q == S_IDLE) | (state_q == S_RESP));
    data_rvalid = (state_q == S_RESP);
  end

  assign data_gnt_o   = gnt;
  assign data_rdata_o = rsp_rdata_q;
  assign rd_out_data  = rsp_tag_q;
  assign data_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// Self-checking bench for data_mem_bank. Four instances cover LATENCY 1..4,
// alternating little/big-endian storage. Expected responses are pushed to a
// per-instance queue at the grant and popped by a monitor on each rvalid.
module tb_data_mem_bank;

  localparam int NDUT  = 4;
  localparam int DEPTH = 8000;
  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      rdata;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req    [NDUT];
  logic [31:0]      addr   [NDUT];
  logic             we_i   [NDUT];
  logic [3:0]       be_i   [NDUT];
  logic [31:0]      wdata  [NDUT];
  logic [TAG_W-1:0] tag_i  [NDUT];
  logic             gnt    [NDUT];
  logic             rvalid [NDUT];
  logic [31:0]      rdata  [NDUT];
  logic [TAG_W-1:0] tag_o  [NDUT];
  logic             err    [NDUT];

  exp_t        sb_q [NDUT][$];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic legal_be(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    data_mem_bank #(
      .DEPTH(DEPTH), .LATENCY(k + 1), .TAG_W(TAG_W), .BIG_ENDIAN(k % 2)
    ) u_dut (
      .clk(clk), .rst(rst),
      .data_req_in(req[k]), .data_add_in(addr[k]), .data_we_in(we_i[k]),
      .data_be_in(be_i[k]), .data_wdata_in(wdata[k]), .rd_in_data(tag_i[k]),
      .data_gnt_o(gnt[k]), .data_rvalid(rvalid[k]), .data_rdata_o(rdata[k]),
      .rd_out_data(tag_o[k]), .data_err_o(err[k])
    );

    logic [31:0]      last_rdata;
    logic [TAG_W-1:0] last_tag;
    logic             last_err;

    always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
        last_rdata <= 32'd0;
        last_tag   <= '0;
        last_err   <= 1'b0;
      end else if (rvalid[k]) begin
        if (sb_q[k].size() == 0) begin
          check($sformatf("dut%0d unexpected rvalid", k), 1, 0);
        end else begin
          e = sb_q[k].pop_front();
          check($sformatf("dut%0d rdata", k), rdata[k], e.rdata);
          check($sformatf("dut%0d tag", k), tag_o[k], e.tag);
          check($sformatf("dut%0d err", k), err[k], e.err);
          check($sformatf("dut%0d latency", k), cyc, e.due);
        end
        last_rdata <= rdata[k];
        last_tag   <= tag_o[k];
        last_err   <= err[k];
      end else begin
        check($sformatf("dut%0d hold rdata", k), rdata[k], last_rdata);
        check($sformatf("dut%0d hold tag", k), tag_o[k], last_tag);
        check($sformatf("dut%0d hold err", k), err[k], last_err);
      end
    end
  end

  // Drive one request, wait for its grant, and record the expected response.
  task automatic issue(input int k, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [TAG_W-1:0] tg);
    exp_t e;
    int   key;
    int   waited;
    logic bad;
    logic [31:0] w;
    @(negedge clk);
    req[k] = 1'b1; we_i[k] = we; addr[k] = a; be_i[k] = be; wdata[k] = wd; tag_i[k] = tg;
    #1;
    waited = 0;
    while (!gnt[k] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!gnt[k]) begin
      check($sformatf("dut%0d grant timeout", k), 0, 1);
      req[k] = 1'b0;
      return;
    end
    bad   = !legal_be(be) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    key   = k * 16384 + int'(a[15:2]);
    e.tag = tg;
    e.err = bad;
    e.due = cyc + k + 1;
    e.rdata = (bad || we) ? 32'd0 : mdl[key];
    if (we && !bad) begin
      w = mdl.exists(key) ? mdl[key] : 32'd0;
      for (int i = 0; i < 4; i++)
        if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      mdl[key] = w;
    end
    sb_q[k].push_back(e);
    @(posedge clk);
    #1 req[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (sb_q[k].size() != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("dut%0d drain", k), sb_q[k].size(), 0);
  endtask

  task automatic run_basic(input int k);
    logic [3:0]  legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [31:0] a;
    logic [3:0]  bev;
    // Full write then back-to-back read of the same word.
    issue(k, 1'b1, 32'h10, 4'b1111, 32'h1122_3344, 5'd1);
    issue(k, 1'b0, 32'h10, 4'b1111, 32'h0,         5'd2);
    // Single-lane update: expect 0x11AA3344.
    issue(k, 1'b1, 32'h10, 4'b0100, 32'h00AA_0000, 5'd3);
    issue(k, 1'b0, 32'h10, 4'b0001, 32'h0,         5'd4);
    // Errors: illegal masks and out-of-range indices leave memory alone.
    issue(k, 1'b1, 32'h10, 4'b0101, 32'hFFFF_FFFF, 5'd5);
    issue(k, 1'b0, 32'h10, 4'b0000, 32'h0,         5'd6);
    issue(k, 1'b1, 32'(4 * DEPTH), 4'b1111, 32'hDEAD_BEEF, 5'd7);
    issue(k, 1'b0, 32'(4 * DEPTH), 4'b1111, 32'h0,         5'd8);
    issue(k, 1'b1, 32'hFFFF_FFFC, 4'b1111, 32'hDEAD_BEEF, 5'd9);
    issue(k, 1'b0, 32'h10, 4'b1111, 32'h0,         5'd10);
    // Last legal word.
    issue(k, 1'b1, 32'(4 * (DEPTH - 1)), 4'b1111, 32'hA5A5_5A5A, 5'd11);
    issue(k, 1'b0, 32'(4 * (DEPTH - 1)), 4'b0010, 32'h0,         5'd12);
    // Every legal mask on one word.
    issue(k, 1'b1, 32'h20, 4'b1111, 32'h0, 5'd13);
    for (int i = 0; i < 7; i++) begin
      issue(k, 1'b1, 32'h20, legal_list[i], 32'h0101_0101 * (i + 1), 5'(14 + i));
      issue(k, 1'b0, 32'h20, 4'b1111, 32'h0, 5'(21 + i));
    end
    // Random mix on a small pre-initialised region.
    for (int j = 0; j < 8; j++)
      issue(k, 1'b1, 32'h100 + 32'(4 * j), 4'b1111, $urandom, 5'(j));
    for (int j = 0; j < 40; j++) begin
      a   = 32'h100 + 32'(4 * $urandom_range(0, 7));
      bev = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) bev = legal_list[$urandom_range(0, 6)];
      if (j % 10 == 9) a = 32'hFFFF_FFF0;
      issue(k, 1'($urandom_range(0, 1)), a, bev, $urandom, 5'($urandom));
    end
    drain(k);
  endtask

  initial begin : global_timeout
    #400000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      req[k] = 1'b0; addr[k] = 32'd0; we_i[k] = 1'b0;
      be_i[k] = 4'd0; wdata[k] = 32'd0; tag_i[k] = '0;
    end

    // Asynchronous reset: outputs clear before any clock edge, no grant.
    #1 rst = 1'b1;
    for (int k = 0; k < NDUT; k++) req[k] = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d reset rvalid", k), rvalid[k], 0);
      check($sformatf("dut%0d reset rdata", k), rdata[k], 0);
      check($sformatf("dut%0d reset tag", k), tag_o[k], 0);
      check($sformatf("dut%0d reset err", k), err[k], 0);
      check($sformatf("dut%0d reset gnt", k), gnt[k], 0);
      req[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    for (int k = 0; k < NDUT; k++) run_basic(k);

    // Storage layout: little-endian keeps the word, big-endian reverses it.
    issue(0, 1'b1, 32'h30, 4'b1111, 32'h1122_3344, 5'd1);
    issue(1, 1'b1, 32'h30, 4'b1111, 32'h1122_3344, 5'd1);
    drain(0);
    drain(1);
    check("dut0 storage word", g_dut[0].u_dut.mem_q[12], 32'h1122_3344);
    check("dut1 storage word", g_dut[1].u_dut.mem_q[12], 32'h4433_2211);
    issue(1, 1'b0, 32'h30, 4'b1111, 32'h0, 5'd2);
    drain(1);

    // LATENCY=3 with the request held high: grant only when idle and in RESP.
    @(negedge clk);
    req[2] = 1'b1; we_i[2] = 1'b0; addr[2] = 32'h10; be_i[2] = 4'b1111; tag_i[2] = 5'd7;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      #1;
      check($sformatf("dut2 held gnt cycle %0d", i), gnt[2], (i == 0 || i == 3));
      if (gnt[2]) begin
        e.rdata = mdl[2 * 16384 + 4];
        e.tag   = 5'd7;
        e.err   = 1'b0;
        e.due   = cyc + 3;
        sb_q[2].push_back(e);
      end
      if (i < 5) @(negedge clk);
    end
    req[2] = 1'b0;
    drain(2);

    // LATENCY=4: reset during WAIT drops the request; memory survives.
    issue(3, 1'b0, 32'h10, 4'b1111, 32'h0, 5'd5);
    drain(3);
    issue(3, 1'b0, 32'h10, 4'b1111, 32'h0, 5'd9);
    @(negedge clk);
    #2 rst = 1'b1;
    req[3] = 1'b1;
    #1;
    check("dut3 rvalid in reset", rvalid[3], 0);
    check("dut3 rdata in reset", rdata[3], 0);
    check("dut3 tag in reset", tag_o[3], 0);
    check("dut3 gnt in reset", gnt[3], 0);
    sb_q[3].delete();
    req[3] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(3, 1'b0, 32'h10, 4'b1111, 32'h0, 5'd11);
    drain(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_bank.md
DATA_MEM_BANK -- requirements
Module: data_mem_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 8000, meaning the number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 1, legal range 1..4, meaning the number of cycles from grant edge to response.
REQ-003 SHALL have parameter TAG_W, default 5, meaning the width of the destination-register tag.
REQ-004 SHALL have parameter BIG_ENDIAN, default 1; 1 means byte-reversed lane storage.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port data_req_in, input, 1 bit: request valid.
REQ-008 SHALL have port data_add_in, input, 32 bits: byte address; word index = data_add_in[31:2].
REQ-009 SHALL have port data_we_in, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port data_be_in, input, 4 bits: byte-lane mask; bit i selects data byte i.
REQ-011 SHALL have port data_wdata_in, input, 32 bits: write data.
REQ-012 SHALL have port rd_in_data, input, TAG_W bits: request tag.
REQ-013 SHALL have port data_gnt_o, output, 1 bit: request accepted this cycle.
REQ-014 SHALL have port data_rvalid, output, 1 bit: response valid, one-cycle pulse.
REQ-015 SHALL have port data_rdata_o, output, 32 bits: read data.
REQ-016 SHALL have port rd_out_data, output, TAG_W bits: tag of the response.
REQ-017 SHALL have port data_err_o, output, 1 bit: response carries an error, qualified by data_rvalid.

Function
REQ-018 SHALL implement states IDLE, WAIT and RESP; at most one request is outstanding.
REQ-019 SHALL drive data_gnt_o combinationally as data_req_in AND (state==IDLE OR state==RESP).
REQ-020 SHALL treat a rising edge with data_req_in=1 and data_gnt_o=1 as the grant edge; request fields are sampled only at that edge.
REQ-021 SHALL, on a grant edge, go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with the down-counter loaded to LATENCY-2.
REQ-022 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-023 SHALL, in RESP, assert data_rvalid=1 for exactly one cycle; the next state is WAIT or RESP on a new grant edge, else IDLE.
REQ-024 SHALL make a granted request at edge T produce data_rvalid high during the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after the grant.
REQ-025 SHALL return rd_out_data equal to the rd_in_data captured at the grant edge, for both reads and writes.
REQ-026 SHALL accept only these legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other mask, including 0000, is an error.
REQ-027 SHALL flag an error when the word index is greater than or equal to DEPTH.
REQ-028 SHALL, on an error, perform no memory update, return data_rdata_o=0 and data_err_o=1.
REQ-029 SHALL commit a legal write at the grant edge to the selected lanes only; unselected lanes are unchanged.
REQ-030 SHALL map lanes as follows: with BIG_ENDIAN=0, data byte i goes to storage byte i; with BIG_ENDIAN=1, data byte i goes to storage byte 3-i; reads apply the inverse mapping.
REQ-031 SHALL capture read data at the grant edge and hold it unchanged until the response.
REQ-032 SHALL return the full 32-bit word for a read regardless of mask, provided the mask is legal.
REQ-033 SHALL return, for a read that follows a write to the same word, the post-write value, including the back-to-back case where the read is granted in the RESP cycle of the write.
REQ-034 SHALL, for a write response, drive data_rdata_o=0.
REQ-035 SHALL hold data_rdata_o, rd_out_data and data_err_o stable from the response until the next response.

Reset
REQ-036 SHALL, with rst=1, force state=IDLE, counter=0, data_rvalid=0, data_err_o=0, data_rdata_o=0 and rd_out_data=0 immediately, without waiting for a clock edge.
REQ-037 SHALL drop a request pending at reset; no response is ever issued for it.
REQ-038 SHALL keep a write already committed before reset in memory; memory contents are not cleared by reset.
REQ-039 SHALL hold data_gnt_o=0 while rst=1.

Verification
REQ-040 Scenario: LATENCY=1, BIG_ENDIAN=0; write 0x11223344 to address 0x10 with be=1111, then read 0x10 -> rvalid one cycle after each grant, read returns 0x11223344, err=0.
REQ-041 Scenario: write be=0100, wdata=0x00AA0000 to a word holding 0x11223344 -> a following read returns 0x11AA3344.
REQ-042 Scenario: BIG_ENDIAN=1; write 0x11223344 with be=1111, then read via the inverse mapping -> returns 0x11223344, and storage word holds 0x44332211.
REQ-043 Scenario: LATENCY=3; issue a read with tag 7, with data_req_in held high -> gnt only at the issue cycle and in the RESP cycle; rvalid exactly 3 cycles after the grant; rd_out_data=7.
REQ-044 Scenario: be=0101, or address 4*DEPTH -> rvalid with err=1 and rdata=0; memory is unchanged.
REQ-045 Scenario: assert rst during WAIT (LATENCY=4) -> rvalid never rises for that request; gnt=0 while rst=1; the next request after reset completes normally.
